aes_round_iter: RTL

//  Iterative AES-128 encryption engine, one round per clock. Drives the 16-byte subbytes stage with
//  the round state each cycle and consumes its output. Follows it with shiftrows, mixcolumns and

---
 rtl/aes_round_iter_if.sv | 12 +
 rtl/aes_round_iter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/aes_round_iter_if.sv
// rtl/aes_round_iter_if.sv - block request/result bundle between the key/plaintext source and the AES engine
interface aes_round_iter_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  modport master (output start, plaintext, key, input busy, done, ciphertext);
  modport slave  (input start, plaintext, key, output busy, done, ciphertext);
endinterface

// File: rtl/aes_round_iter.sv
// rtl/aes_round_iter.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // entry 0 sits in the top byte of the packed table
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_subbytes (
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a(a[8*i +: 8]), .y(y[8*i +: 8]));
  end
endmodule

module aes_round_iter #(
  parameter bit CLEAR_CT_ON_START = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  aes_round_iter_if.slave bus
);
  typedef enum logic {IDLE, ROUND} fsm_t;

  fsm_t         fsm, fsm_nx;
  logic [127:0] state, state_nx, round_key, rk_nx, ct_q, ct_nx;
  logic [7:0]   rcon, rcon_nx;
  logic [3:0]   round, round_nx;
  logic         busy_q, busy_nx, done_q, done_nx;
  logic [127:0] sb_out, sr_out, mc_out, next_rk;
  logic [31:0]  rot_w3, sub_w3, w0n, w1n, w2n, w3n;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // byte (row r, column c) lives at [127-8*(4c+r) -: 8]
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  aes_subbytes u_subbytes (.a(state), .y(sb_out));

  assign rot_w3 = {round_key[23:0], round_key[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_ksb
    aes_sbox u_ksbox (.a(rot_w3[8*i +: 8]), .y(sub_w3[8*i +: 8]));
  end

  assign w0n     = round_key[127:96] ^ sub_w3 ^ {rcon, 24'h0};
  assign w1n     = round_key[95:64] ^ w0n;
  assign w2n     = round_key[63:32] ^ w1n;
  assign w3n     = round_key[31:0] ^ w2n;
  assign next_rk = {w0n, w1n, w2n, w3n};
  assign sr_out  = shift_rows(sb_out);
  assign mc_out  = mix_columns(sr_out);

  always_comb begin
    fsm_nx   = fsm;
    state_nx = state;
    rk_nx    = round_key;
    rcon_nx  = rcon;
    round_nx = round;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    ct_nx    = ct_q;
    case (fsm)
      IDLE: begin
        if (bus.start) begin
          state_nx = bus.plaintext ^ bus.key;
          rk_nx    = bus.key;
          rcon_nx  = 8'h01;
          round_nx = 4'd1;
          busy_nx  = 1'b1;
          fsm_nx   = ROUND;
          if (CLEAR_CT_ON_START) ct_nx = '0;
        end
      end
      ROUND: begin
        rk_nx   = next_rk;
        rcon_nx = xt(rcon);
        if (round == 4'd10) begin
          state_nx = sr_out ^ next_rk;
          ct_nx    = sr_out ^ next_rk;
          round_nx = 4'd0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          fsm_nx   = IDLE;
        end else begin
          state_nx = mc_out ^ next_rk;
          round_nx = round + 4'd1;
        end
      end
      default: fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      round_key <= '0;
      rcon      <= '0;
      round     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ct_q      <= '0;
    end else begin
      fsm       <= fsm_nx;
      state     <= state_nx;
      round_key <= rk_nx;
      rcon      <= rcon_nx;
      round     <= round_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      ct_q      <= ct_nx;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ciphertext = ct_q;
endmodule
